// File: rtl/ahb_lite_arb2.sv
// Two-master AHB-Lite arbiter in front of the block-RAM slave.
// A master that is not issued immediately is held in a one-deep buffer and stalled.
module ahb_lite_arb2 #(
   parameter int FIXED_PRIO = 0,
   parameter int AW         = 32
) (
   input  logic            sys_clk,
   input  logic            sys_resetn,
   input  logic [3:0]      m_htrans,
   input  logic [2*AW-1:0] m_haddr,
   input  logic [1:0]      m_hwrite,
   input  logic [3:0]      m_hsize,
   input  logic [5:0]      m_hburst,
   input  logic [7:0]      m_hprot,
   input  logic [63:0]     m_hwdata,
   output logic [31:0]     m_hrdata,
   output logic [1:0]      m_hready,
   output logic [1:0]      m_hresp,
   output logic [1:0]      s_htrans,
   output logic [AW-1:0]   s_haddr,
   output logic            s_hwrite,
   output logic [1:0]      s_hsize,
   output logic [2:0]      s_hburst,
   output logic [3:0]      s_hprot,
   output logic [31:0]     s_hwdata,
   input  logic [31:0]     s_hrdata,
   input  logic            s_hready,
   input  logic            s_hresp
);

   logic [1:0]    pend_valid;
   logic [AW-1:0] pend_addr  [2];
   logic [1:0]    pend_trans [2];
   logic          pend_write [2];
   logic [1:0]    pend_size  [2];
   logic [2:0]    pend_burst [2];
   logic [3:0]    pend_prot  [2];

   logic          dp_valid;
   logic          dp_owner;
   logic          last_grant;

   logic [1:0]    live;
   logic [1:0]    req;
   logic          winner;
   logic          issue;

   logic [AW-1:0] f_addr  [2];
   logic [1:0]    f_trans [2];
   logic          f_write [2];
   logic [1:0]    f_size  [2];
   logic [2:0]    f_burst [2];
   logic [3:0]    f_prot  [2];

   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         m_hready[i] = pend_valid[i] ? 1'b0 :
                       (dp_valid && dp_owner == 1'(i)) ? s_hready : 1'b1;
         m_hresp[i]  = (dp_valid && dp_owner == 1'(i)) ? s_hresp : 1'b0;
      end
   end

   // A live request is only seen while the master is not stalled; a buffered one wins over live inputs.
   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         live[i]    = m_htrans[2*i+1] & m_hready[i];
         req[i]     = pend_valid[i] | live[i];
         f_addr[i]  = pend_valid[i] ? pend_addr[i]  : m_haddr[AW*i +: AW];
         f_trans[i] = pend_valid[i] ? pend_trans[i] : m_htrans[2*i +: 2];
         f_write[i] = pend_valid[i] ? pend_write[i] : m_hwrite[i];
         f_size[i]  = pend_valid[i] ? pend_size[i]  : m_hsize[2*i +: 2];
         f_burst[i] = pend_valid[i] ? pend_burst[i] : m_hburst[3*i +: 3];
         f_prot[i]  = pend_valid[i] ? pend_prot[i]  : m_hprot[4*i +: 4];
      end
   end

   always_comb begin
      if (req == 2'b11)
         winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
      else
         winner = req[1];
   end

   assign issue = sys_resetn & s_hready & (|req);

   always_comb begin
      s_htrans = '0;
      s_haddr  = '0;
      s_hwrite = 1'b0;
      s_hsize  = '0;
      s_hburst = '0;
      s_hprot  = '0;
      if (issue) begin
         s_htrans = f_trans[winner];
         s_haddr  = f_addr[winner];
         s_hwrite = f_write[winner];
         s_hsize  = f_size[winner];
         s_hburst = f_burst[winner];
         s_hprot  = f_prot[winner];
      end
   end

   assign s_hwdata = !dp_valid ? '0 : (dp_owner ? m_hwdata[63:32] : m_hwdata[31:0]);
   assign m_hrdata = s_hrdata;

   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         pend_valid <= '0;
         dp_valid   <= 1'b0;
         dp_owner   <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         if (issue) begin
            dp_valid   <= 1'b1;
            dp_owner   <= winner;
            last_grant <= winner;
         end else if (s_hready) begin
            dp_valid   <= 1'b0;
         end
         for (int unsigned i = 0; i < 2; i++) begin
            if (issue && winner == 1'(i))
               pend_valid[i] <= 1'b0;
            else if (live[i])
               pend_valid[i] <= 1'b1;
         end
      end
   end

   // Buffer fields only matter while pend_valid is set, so they need no reset.
   always_ff @(posedge sys_clk) begin
      for (int unsigned i = 0; i < 2; i++) begin
         if (live[i] && !(issue && winner == 1'(i))) begin
            pend_addr[i]  <= m_haddr[AW*i +: AW];
            pend_trans[i] <= m_htrans[2*i +: 2];
            pend_write[i] <= m_hwrite[i];
            pend_size[i]  <= m_hsize[2*i +: 2];
            pend_burst[i] <= m_hburst[3*i +: 3];
            pend_prot[i]  <= m_hprot[4*i +: 4];
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// Randomized bench for ahb_lite_arb2 against a queue-based reference model,
// plus a short fixed-priority run on a second instance.
module tb_ahb_lite_arb2;

   logic        sys_clk = 1'b0;
   logic        sys_resetn = 1'b0;
   logic [3:0]  m_htrans = '0;
   logic [63:0] m_haddr = '0;
   logic [1:0]  m_hwrite = '0;
   logic [3:0]  m_hsize = '0;
   logic [5:0]  m_hburst = '0;
   logic [7:0]  m_hprot = '0;
   logic [63:0] m_hwdata = '0;
   logic [31:0] m_hrdata;
   logic [1:0]  m_hready, m_hresp, s_htrans, s_hsize;
   logic [31:0] s_haddr, s_hwdata;
   logic        s_hwrite;
   logic [2:0]  s_hburst;
   logic [3:0]  s_hprot;
   logic [31:0] s_hrdata = '0;
   logic        s_hready = 1'b1;
   logic        s_hresp = 1'b0;

   logic [3:0]  f_htrans = '0;
   logic [63:0] f_haddr = '0;
   logic [31:0] f_m_hrdata, f_s_haddr, f_s_hwdata;
   logic [1:0]  f_m_hready, f_m_hresp, f_s_htrans, f_s_hsize;
   logic        f_s_hwrite;
   logic [2:0]  f_s_hburst;
   logic [3:0]  f_s_hprot;

   always #5 sys_clk = ~sys_clk;

   ahb_lite_arb2 #(.FIXED_PRIO(0), .AW(32)) dut (
      .sys_clk(sys_clk), .sys_resetn(sys_resetn),
      .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite),
      .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hprot(m_hprot),
      .m_hwdata(m_hwdata), .m_hrdata(m_hrdata), .m_hready(m_hready),
      .m_hresp(m_hresp), .s_htrans(s_htrans), .s_haddr(s_haddr),
      .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
      .s_hprot(s_hprot), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
      .s_hready(s_hready), .s_hresp(s_hresp)
   );

   ahb_lite_arb2 #(.FIXED_PRIO(1), .AW(32)) dut_fp (
      .sys_clk(sys_clk), .sys_resetn(sys_resetn),
      .m_htrans(f_htrans), .m_haddr(f_haddr), .m_hwrite(2'b00),
      .m_hsize(4'h0), .m_hburst(6'h0), .m_hprot(8'h0),
      .m_hwdata(64'h0), .m_hrdata(f_m_hrdata), .m_hready(f_m_hready),
      .m_hresp(f_m_hresp), .s_htrans(f_s_htrans), .s_haddr(f_s_haddr),
      .s_hwrite(f_s_hwrite), .s_hsize(f_s_hsize), .s_hburst(f_s_hburst),
      .s_hprot(f_s_hprot), .s_hwdata(f_s_hwdata), .s_hrdata(32'h0),
      .s_hready(1'b1), .s_hresp(1'b0)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        wr;
      logic [1:0]  size;
      logic [2:0]  burst;
      logic [3:0]  prot;
   } ph_t;

   // Reference state: one waiting-request queue per master, who owns the data phase, who won last.
   ph_t  pend_q [2][$];
   bit   md_v = 1'b0;
   int   md_own = 0;
   int   m_last = 1;
   logic [1:0] exp_rdy = 2'b11;

   task automatic model_step();
      ph_t  live_ph [2];
      bit   live_ok [2];
      bit   want [2];
      logic [1:0] eh, er;
      int   win;
      bit   go;
      ph_t  g;
      if (!sys_resetn) begin
         pend_q[0].delete();
         pend_q[1].delete();
         md_v = 1'b0;
         m_last = 1;
         exp_rdy = 2'b11;
         chk("rst_hready", m_hready, 2'b11);
         chk("rst_hresp", m_hresp, 2'b00);
         chk("rst_htrans", s_htrans, 2'b00);
         chk("rst_haddr", s_haddr, 32'h0);
         chk("rst_hwdata", s_hwdata, 32'h0);
         return;
      end
      for (int i = 0; i < 2; i++) begin
         eh[i] = (pend_q[i].size() != 0) ? 1'b0 : (md_v && md_own == i) ? s_hready : 1'b1;
         er[i] = (md_v && md_own == i) ? s_hresp : 1'b0;
         live_ph[i].addr  = m_haddr[32*i +: 32];
         live_ph[i].trans = m_htrans[2*i +: 2];
         live_ph[i].wr    = m_hwrite[i];
         live_ph[i].size  = m_hsize[2*i +: 2];
         live_ph[i].burst = m_hburst[3*i +: 3];
         live_ph[i].prot  = m_hprot[4*i +: 4];
         live_ok[i] = eh[i] && live_ph[i].trans[1];
         want[i]    = (pend_q[i].size() != 0) || live_ok[i];
      end
      if (want[0] && want[1]) win = 1 - m_last;
      else win = want[1] ? 1 : 0;
      go = s_hready && (want[0] || want[1]);
      g = '0;
      if (go) g = (pend_q[win].size() != 0) ? pend_q[win][0] : live_ph[win];

      chk("m_hready", m_hready, eh);
      chk("m_hresp", m_hresp, er);
      chk("s_htrans", s_htrans, g.trans);
      chk("s_haddr", s_haddr, g.addr);
      chk("s_hwrite", s_hwrite, g.wr);
      chk("s_hsize", s_hsize, g.size);
      chk("s_hburst", s_hburst, g.burst);
      chk("s_hprot", s_hprot, g.prot);
      chk("s_hwdata", s_hwdata, md_v ? m_hwdata[32*md_own +: 32] : 32'h0);
      chk("m_hrdata", m_hrdata, s_hrdata);

      if (go) begin
         if (pend_q[win].size() != 0) void'(pend_q[win].pop_front());
         md_v = 1'b1;
         md_own = win;
         m_last = win;
      end else if (s_hready) begin
         md_v = 1'b0;
      end
      for (int i = 0; i < 2; i++)
         if (live_ok[i] && !(go && win == i)) pend_q[i].push_back(live_ph[i]);
      exp_rdy = eh;
   endtask

   task automatic drive_masters(input bit force_ns);
      int r;
      logic [1:0] tr;
      for (int i = 0; i < 2; i++) begin
         if (exp_rdy[i]) begin
            r = $urandom_range(0, 9);
            tr = force_ns ? 2'b10 : (r < 5) ? 2'b10 : (r < 7) ? 2'b11 : (r < 8) ? 2'b01 : 2'b00;
            m_htrans[2*i +: 2] = tr;
            m_haddr[32*i +: 32] = $urandom & 32'h0000_FFFC;
            m_hwrite[i]         = 1'($urandom);
            m_hsize[2*i +: 2]   = 2'($urandom);
            m_hburst[3*i +: 3]  = 3'($urandom);
            m_hprot[4*i +: 4]   = 4'($urandom);
            m_hwdata[32*i +: 32] = $urandom;
         end
      end
   endtask

   int  err_stage = 0;
   int  rst_hold = 0;
   bit  mid_rst_done = 1'b0;
   bit  m0, prev_m0;
   logic [31:0] a0;

   initial begin
      // Reset held with both masters driving NONSEQ.
      for (int c = 0; c < 3; c++) begin
         @(posedge sys_clk); #1;
         drive_masters(1'b1);
         @(negedge sys_clk);
         model_step();
      end
      @(posedge sys_clk); #1;
      sys_resetn = 1'b1;
      drive_masters(1'b1);
      @(negedge sys_clk);
      chk("first_tie_m0", s_haddr, m_haddr[31:0]);
      model_step();

      for (int c = 0; c < 3000; c++) begin
         @(posedge sys_clk); #1;
         drive_masters(1'b0);
         s_hrdata = $urandom;
         if (err_stage == 1) begin
            s_hready = 1'b1;
            s_hresp  = 1'b1;
            err_stage = 0;
         end else if (md_v && $urandom_range(0, 7) == 0) begin
            s_hready = 1'b0;
            s_hresp  = 1'b1;
            err_stage = 1;
         end else begin
            s_hready = md_v ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_hresp  = 1'b0;
         end
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) sys_resetn = 1'b1;
         end else if (!mid_rst_done && c > 1500 && pend_q[0].size() != 0) begin
            mid_rst_done = 1'b1;
            sys_resetn = 1'b0;
            err_stage = 0;
            rst_hold = 2;
            #1;
            chk("arst_hready", m_hready, 2'b11);
            chk("arst_htrans", s_htrans, 2'b00);
         end
         @(negedge sys_clk);
         model_step();
      end
      chk("mid_reset_seen", mid_rst_done, 1'b1);

      // Fixed priority: master 1 requests constantly and only gets in when master 0 idles.
      m_htrans = '0;
      prev_m0 = 1'b0;
      for (int t = 0; t < 24; t++) begin
         @(posedge sys_clk); #1;
         m0 = (t == 0) || ($urandom_range(0, 2) != 0);
         a0 = 32'h1000 + 32'(t * 4);
         f_htrans = {2'b10, m0 ? 2'b10 : 2'b00};
         f_haddr  = {32'h0000_0200, a0};
         @(negedge sys_clk);
         chk("fp_haddr", f_s_haddr, m0 ? a0 : 32'h200);
         chk("fp_htrans", f_s_htrans, 2'b10);
         chk("fp_hready0", f_m_hready[0], 1'b1);
         if (t > 0) chk("fp_hready1", f_m_hready[1], !prev_m0);
         prev_m0 = m0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
